// File: rtl/dec_onehot_seq.sv
// Registered index-to-one-hot decoder with valid/ready handshakes on both sides.
// Single mode emits one beat; scan mode walks the one-hot bit over an inclusive index range.
module dec_onehot_seq #(
  parameter int IDX_W   = 5,
  parameter int NUM_OUT = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic               in_mode,
  input  logic [IDX_W-1:0]   in_idx,
  input  logic [IDX_W-1:0]   in_end_idx,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [NUM_OUT-1:0] out_onehot,
  output logic               out_last,
  output logic               out_err,
  output logic               busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // One extra bit so NUM_OUT == 2**IDX_W still compares correctly.
  localparam logic [IDX_W:0] LP_NUM_OUT = (IDX_W+1)'(NUM_OUT);

  function automatic logic f_in_range(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < LP_NUM_OUT);
  endfunction

  function automatic logic [NUM_OUT-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_OUT-1:0] res;
    for (int i = 0; i < NUM_OUT; i++) begin
      res[i] = (idx == IDX_W'(i));
    end
    return res;
  endfunction

  state_t             r_state;
  logic [IDX_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_end;
  logic               r_vld;
  logic [NUM_OUT-1:0] r_onehot;
  logic               r_last;
  logic               r_err;

  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   w_end_nxt;
  logic               w_vld_nxt;
  logic [NUM_OUT-1:0] w_oh_nxt;
  logic               w_last_nxt;
  logic               w_err_nxt;

  logic               w_load;
  logic               w_accept;
  logic               w_scan_legal;
  logic [IDX_W-1:0]   w_cnt_inc;

  assign w_load       = !r_vld || out_rdy;
  assign in_rdy       = rst_n && (r_state == ST_IDLE) && w_load;
  assign w_accept     = in_vld && in_rdy;
  assign w_scan_legal = (in_idx <= in_end_idx) && f_in_range(in_end_idx);
  assign w_cnt_inc    = r_cnt + IDX_W'(1);

  assign out_vld    = r_vld;
  assign out_onehot = r_onehot;
  assign out_last   = r_last;
  assign out_err    = r_err;
  assign busy       = (r_state != ST_IDLE) || r_vld;

  // Next-state and next-beat logic for the request FSM and output stage.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_end_nxt   = r_end;
    w_vld_nxt   = r_vld;
    w_oh_nxt    = r_onehot;
    w_last_nxt  = r_last;
    w_err_nxt   = r_err;

    if (r_vld && out_rdy) begin
      w_vld_nxt = 1'b0;
    end else begin
      w_vld_nxt = r_vld;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_vld_nxt  = 1'b1;
          w_last_nxt = 1'b1;
          if (!in_mode) begin
            if (f_in_range(in_idx)) begin
              w_oh_nxt  = f_onehot(in_idx);
              w_err_nxt = 1'b0;
            end else begin
              w_oh_nxt  = {NUM_OUT{1'b0}};
              w_err_nxt = 1'b1;
            end
          end else if (w_scan_legal) begin
            w_oh_nxt  = f_onehot(in_idx);
            w_err_nxt = 1'b0;
            w_cnt_nxt = in_idx;
            w_end_nxt = in_end_idx;
            // A one-index scan finishes on its first beat and never leaves IDLE.
            if (in_idx != in_end_idx) begin
              w_last_nxt  = 1'b0;
              w_state_nxt = ST_SCAN;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_oh_nxt  = {NUM_OUT{1'b0}};
            w_err_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (w_load) begin
          w_cnt_nxt   = w_cnt_inc;
          w_vld_nxt   = 1'b1;
          w_oh_nxt    = f_onehot(w_cnt_inc);
          w_err_nxt   = 1'b0;
          w_last_nxt  = (w_cnt_inc == r_end);
          w_state_nxt = (w_cnt_inc == r_end) ? ST_IDLE : ST_SCAN;
        end else begin
          w_state_nxt = ST_SCAN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_vld_nxt   = 1'b0;
        w_oh_nxt    = {NUM_OUT{1'b0}};
        w_last_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= {IDX_W{1'b0}};
      r_end    <= {IDX_W{1'b0}};
      r_vld    <= 1'b0;
      r_onehot <= {NUM_OUT{1'b0}};
      r_last   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_end    <= w_end_nxt;
      r_vld    <= w_vld_nxt;
      r_onehot <= w_oh_nxt;
      r_last   <= w_last_nxt;
      r_err    <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Scoreboard bench for dec_onehot_seq: requests push their expected beats into a queue,
// a negedge monitor pops and compares every presented beat and the handshake signals.
module tb_dec_onehot_seq;

  localparam int IDX_W = 5;

  typedef struct packed {
    logic [31:0] oh;
    logic        last;
    logic        err;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld, in_mode, out_rdy;
  logic [4:0]  in_idx, in_end_idx;
  logic        in_rdy, out_vld, out_last, out_err, busy;
  logic [31:0] out_onehot;

  // Second instance with a narrower output for out-of-range checks.
  logic        s_vld, s_mode, s_out_rdy;
  logic [4:0]  s_idx, s_end;
  logic        s_in_rdy, s_out_vld, s_out_last, s_out_err, s_busy;
  logic [19:0] s_onehot;

  int n_checks = 0;
  int n_errors = 0;
  beat_t sb_q[$];

  always #5 clk = ~clk;

  dec_onehot_seq #(.IDX_W(IDX_W), .NUM_OUT(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_mode(in_mode),
    .in_idx(in_idx), .in_end_idx(in_end_idx), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_onehot(out_onehot), .out_last(out_last), .out_err(out_err), .busy(busy)
  );

  dec_onehot_seq #(.IDX_W(IDX_W), .NUM_OUT(20)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .in_vld(s_vld), .in_rdy(s_in_rdy), .in_mode(s_mode),
    .in_idx(s_idx), .in_end_idx(s_end), .out_vld(s_out_vld), .out_rdy(s_out_rdy),
    .out_onehot(s_onehot), .out_last(s_out_last), .out_err(s_out_err), .busy(s_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the full list of beats a request must produce, from the rules alone.
  task automatic model_push(input logic mode, input int s, input int e, input int num);
    beat_t b;
    if (!mode) begin
      b.oh = (s < num) ? (32'd1 << s) : 32'd0;
      b.last = 1'b1;
      b.err = (s >= num);
      sb_q.push_back(b);
    end else if (s <= e && e < num) begin
      for (int k = s; k <= e; k++) begin
        b.oh = 32'd1 << k;
        b.last = (k == e);
        b.err = 1'b0;
        sb_q.push_back(b);
      end
    end else begin
      b.oh = 32'd0;
      b.last = 1'b1;
      b.err = 1'b1;
      sb_q.push_back(b);
    end
  endtask

  // Monitor: handshake expectations from queue occupancy, beat compare, request capture.
  always @(negedge clk) begin
    int sz;
    beat_t b;
    sz = sb_q.size();
    if (!rst_n) begin
      sb_q.delete();
      check("in_rdy_in_reset", {63'd0, in_rdy}, 64'd0);
    end else begin
      check("busy", {63'd0, busy}, {63'd0, sz != 0});
      check("out_vld", {63'd0, out_vld}, {63'd0, sz != 0});
      check("in_rdy", {63'd0, in_rdy}, {63'd0, (sz == 0) || (sz == 1 && out_rdy)});
      if (out_vld && sz != 0) begin
        b = sb_q[0];
        check("out_onehot", {32'd0, out_onehot}, {32'd0, b.oh});
        check("out_last", {63'd0, out_last}, {63'd0, b.last});
        check("out_err", {63'd0, out_err}, {63'd0, b.err});
        if (out_rdy) void'(sb_q.pop_front());
      end
      if (in_vld && in_rdy) model_push(in_mode, int'(in_idx), int'(in_end_idx), 32);
    end
  end

  // Present one request and hold it until accepted; optionally jitter out_rdy while waiting.
  task automatic req(input logic mode, input int s, input int e, input bit rand_rdy);
    int waited = 0;
    in_vld = 1'b1;
    in_mode = mode;
    in_idx = 5'(s);
    in_end_idx = 5'(e);
    forever begin
      @(negedge clk);
      if (in_rdy) break;
      waited++;
      if (waited > 100) begin
        check("req_accept_timeout", 64'd0, 64'd1);
        break;
      end
      @(posedge clk); #1;
      if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_rdy = 1'b1;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic chk20(input logic mode, input int s, input int e, input logic [19:0] oh,
                       input logic err);
    s_vld = 1'b1;
    s_mode = mode;
    s_idx = 5'(s);
    s_end = 5'(e);
    @(negedge clk);
    check("n20_in_rdy", {63'd0, s_in_rdy}, 64'd1);
    @(posedge clk); #1;
    s_vld = 1'b0;
    @(negedge clk);
    check("n20_out_vld", {63'd0, s_out_vld}, 64'd1);
    check("n20_onehot", {44'd0, s_onehot}, {44'd0, oh});
    check("n20_err", {63'd0, s_out_err}, {63'd0, err});
    check("n20_last", {63'd0, s_out_last}, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic pat[7];
    int s, e;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    rst_n = 1'b0; in_vld = 1'b0; in_mode = 1'b0; in_idx = 5'd0; in_end_idx = 5'd0;
    out_rdy = 1'b1;
    s_vld = 1'b0; s_mode = 1'b0; s_idx = 5'd0; s_end = 5'd0; s_out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_vld", {63'd0, out_vld}, 64'd0);
    check("rst_onehot", {32'd0, out_onehot}, 64'd0);
    check("rst_last", {63'd0, out_last}, 64'd0);
    check("rst_err", {63'd0, out_err}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    chk20(1'b0, 25, 0, 20'd0, 1'b1);
    chk20(1'b0, 19, 0, 20'h80000, 1'b0);
    chk20(1'b1, 3, 20, 20'd0, 1'b1);
    chk20(1'b1, 5, 5, 20'h00020, 1'b0);

    // Back-to-back singles: in_vld stays high across requests.
    req(1'b0, 0, 0, 1'b0);
    req(1'b0, 5, 0, 1'b0);
    req(1'b0, 31, 0, 1'b0);
    drain();
    req(1'b1, 3, 6, 1'b0);
    drain();

    req(1'b1, 0, 3, 1'b0);
    for (int i = 0; i < 7; i++) begin
      out_rdy = pat[i];
      @(posedge clk); #1;
    end
    drain();

    req(1'b1, 7, 2, 1'b0);
    req(1'b1, 10, 40, 1'b0);
    req(1'b1, 9, 9, 1'b0);
    drain();

    // Reset during the second beat of a long scan.
    req(1'b1, 0, 15, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_vld", {63'd0, out_vld}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_onehot", {32'd0, out_onehot}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req(1'b0, 2, 0, 1'b0);
    drain();

    for (int n = 0; n < 300; n++) begin
      out_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        s = $urandom_range(0, 31);
        e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : s + $urandom_range(0, 6);
        if (e > 31) e = 31;
        req(1'b1 & $urandom_range(0, 1), s, e, 1'b1);
      end else begin
        @(posedge clk); #1;
      end
    end
    drain();
    @(negedge clk);
    check("queue_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
